// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Pipeline stage register with a ready/valid handshake, a
//               two-entry skid buffer and flush to a bubble value. Defining
//               PIPE_STALL_CNT_EN adds a saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int                WIDTH   = 32,
    parameter logic [WIDTH-1:0]  NOP_VAL = '0,
    parameter int                CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [WIDTH-1:0] IN,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] OUT,
    output logic             out_valid,
    input  logic             out_ready
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
        $error("pipe_stage_reg: WIDTH and CNT_W must be at least 1");
    end

    logic [WIDTH-1:0] r_main_d;
    logic             r_main_v;
    logic [WIDTH-1:0] r_skid_d;
    logic             r_skid_v;
    logic             w_accept;
    logic             w_consume;

    // Ready depends only on registered state, never on out_ready.
    assign in_ready  = !r_skid_v;
    assign OUT       = r_main_d;
    assign out_valid = r_main_v;
    assign w_accept  = in_valid & in_ready;
    assign w_consume = r_main_v & out_ready;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_main_d <= NOP_VAL;
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else if (flush) begin
            r_main_d <= NOP_VAL;
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else if (w_consume || !r_main_v) begin
            if (r_skid_v) begin
                r_main_d <= r_skid_d;
                r_main_v <= 1'b1;
                r_skid_v <= 1'b0;
            end else if (w_accept) begin
                r_main_d <= IN;
                r_main_v <= 1'b1;
            end else begin
                r_main_v <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_d <= IN;
            r_skid_v <= 1'b1;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Flush deliberately leaves the count untouched.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_stall_cnt <= '0;
        end else if (r_main_v && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
`endif

endmodule
`default_nettype wire
